// File: rtl/issue_pkg.sv
// Shared encodings for the issue-select block: functional-unit classes and
// data-unit handshake states.
package issue_pkg;

    typedef enum logic [1:0] {
        CLS_ALU  = 2'b00,
        CLS_BU   = 2'b01,
        CLS_DU   = 2'b10,
        CLS_NONE = 2'b11
    } fu_cls_e;

    typedef enum logic {
        DU_IDLE = 1'b0,
        DU_WAIT = 1'b1
    } du_state_e;

endpackage

// File: rtl/age_pick.sv
// Circular find-first over a DEPTH-bit request vector, starting at head and
// wrapping DEPTH-1 -> 0; the entry closest to head in age order wins.
module age_pick
    import issue_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] vec,
    input  logic [IDX_W-1:0] head,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W:0] pos;

    // Scan from youngest to oldest so the oldest hit is the last assignment.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            pos = {1'b0, head} + (IDX_W + 1)'(k);
            if (pos >= (IDX_W + 1)'(DEPTH))
                pos = pos - (IDX_W + 1)'(DEPTH);
            if (vec[pos[IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/issue_select.sv
// Age-ordered issue select for two ALUs, one branch unit and one data unit.
// Optional stall counter enabled by defining ISSUE_SELECT_PERF_EN.
module issue_select
    import issue_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [DEPTH-1:0]   req_ready,
    input  logic [2*DEPTH-1:0] req_class,
    input  logic [IDX_W-1:0]   head_ptr,
    input  logic               du_busy,
    input  logic               du_done,
    output logic               alu0_en,
    output logic               alu1_en,
    output logic               bu_en,
    output logic               du_en,
    output logic [IDX_W-1:0]   alu0_idx,
    output logic [IDX_W-1:0]   alu1_idx,
    output logic [IDX_W-1:0]   bu_idx,
    output logic [IDX_W-1:0]   du_idx,
`ifdef ISSUE_SELECT_PERF_EN
    output logic [15:0]        stall_cnt,
`endif
    output logic [DEPTH-1:0]   sel_mask
);

    function automatic logic [DEPTH-1:0] onehot(input logic [IDX_W-1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    du_state_e        du_state;
    logic [DEPTH-1:0] cand_p0, alu_vec_p0, alu_rem_p0, bu_vec_p0, du_vec_p0;
    logic             alu0_found_p0, alu1_found_p0, bu_found_p0, du_found_p0;
    logic [IDX_W-1:0] alu0_pick_p0, alu1_pick_p0, bu_pick_p0, du_pick_p0;
    logic             du_grant_p0;
    logic [DEPTH-1:0] sel_p0;

    // ---- stage p0: candidate split by class (sel_mask doubles as inflight mask)
    assign cand_p0 = req_ready & ~sel_mask;

    always_comb begin
        alu_vec_p0 = '0;
        bu_vec_p0  = '0;
        du_vec_p0  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            case (fu_cls_e'(req_class[2*i +: 2]))
                CLS_ALU: alu_vec_p0[i] = cand_p0[i];
                CLS_BU:  bu_vec_p0[i]  = cand_p0[i];
                CLS_DU:  du_vec_p0[i]  = cand_p0[i];
                default: ;
            endcase
        end
    end

    age_pick #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_pick_alu0 (
        .vec(alu_vec_p0), .head(head_ptr), .found(alu0_found_p0), .idx(alu0_pick_p0)
    );

    assign alu_rem_p0 = alu_vec_p0 & ~onehot(alu0_pick_p0);

    age_pick #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_pick_alu1 (
        .vec(alu_rem_p0), .head(head_ptr), .found(alu1_found_p0), .idx(alu1_pick_p0)
    );

    age_pick #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_pick_bu (
        .vec(bu_vec_p0), .head(head_ptr), .found(bu_found_p0), .idx(bu_pick_p0)
    );

    age_pick #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_pick_du (
        .vec(du_vec_p0), .head(head_ptr), .found(du_found_p0), .idx(du_pick_p0)
    );

    assign du_grant_p0 = du_found_p0 && (du_state == DU_IDLE) && !du_busy;

    assign sel_p0 = (alu0_found_p0 ? onehot(alu0_pick_p0) : '0)
                  | (alu1_found_p0 ? onehot(alu1_pick_p0) : '0)
                  | (bu_found_p0   ? onehot(bu_pick_p0)   : '0)
                  | (du_grant_p0   ? onehot(du_pick_p0)   : '0);

    // ---- stage p1: registered grants and DU handshake state
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            alu0_en  <= 1'b0;
            alu1_en  <= 1'b0;
            bu_en    <= 1'b0;
            du_en    <= 1'b0;
            alu0_idx <= '0;
            alu1_idx <= '0;
            bu_idx   <= '0;
            du_idx   <= '0;
            sel_mask <= '0;
            du_state <= DU_IDLE;
        end else begin
            alu0_en  <= alu0_found_p0;
            alu1_en  <= alu1_found_p0;
            bu_en    <= bu_found_p0;
            du_en    <= du_grant_p0;
            alu0_idx <= alu0_found_p0 ? alu0_pick_p0 : '0;
            alu1_idx <= alu1_found_p0 ? alu1_pick_p0 : '0;
            bu_idx   <= bu_found_p0   ? bu_pick_p0   : '0;
            du_idx   <= du_grant_p0   ? du_pick_p0   : '0;
            sel_mask <= sel_p0;
            case (du_state)
                DU_IDLE: if (du_grant_p0) du_state <= DU_WAIT;
                DU_WAIT: if (du_done)     du_state <= DU_IDLE;
                default:                  du_state <= DU_IDLE;
            endcase
        end
    end

`ifdef ISSUE_SELECT_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst)
            stall_cnt <= '0;
        else if ((cand_p0 != '0) && (sel_p0 == '0) && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_issue_select.sv
// Self-checking bench for issue_select: directed age/DU/flush scenarios plus
// randomized traffic against an age-sorting reference model.
module tb_issue_select;

    localparam int DEPTH = 16;
    localparam int IDX_W = $clog2(DEPTH);

    logic               clk;
    logic               rst;
    logic               flush;
    logic [DEPTH-1:0]   req_ready;
    logic [2*DEPTH-1:0] req_class;
    logic [IDX_W-1:0]   head_ptr;
    logic               du_busy;
    logic               du_done;
    logic               alu0_en, alu1_en, bu_en, du_en;
    logic [IDX_W-1:0]   alu0_idx, alu1_idx, bu_idx, du_idx;
    logic [DEPTH-1:0]   sel_mask;
`ifdef ISSUE_SELECT_PERF_EN
    logic [15:0]        stall_cnt;
`endif

    issue_select #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_ready(req_ready), .req_class(req_class), .head_ptr(head_ptr),
        .du_busy(du_busy), .du_done(du_done),
        .alu0_en(alu0_en), .alu1_en(alu1_en), .bu_en(bu_en), .du_en(du_en),
        .alu0_idx(alu0_idx), .alu1_idx(alu1_idx), .bu_idx(bu_idx), .du_idx(du_idx),
`ifdef ISSUE_SELECT_PERF_EN
        .stall_cnt(stall_cnt),
`endif
        .sel_mask(sel_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Reference model state and expected outputs
    logic [DEPTH-1:0] m_infl = '0;
    logic             m_wait = 1'b0;
    logic             nxt_wait;
    logic             e_alu0_en, e_alu1_en, e_bu_en, e_du_en;
    int               e_alu0_idx, e_alu1_idx, e_bu_idx, e_du_idx;
    logic [DEPTH-1:0] e_sel;

    function automatic int age(input int i);
        return (i - int'(head_ptr) + DEPTH) % DEPTH;
    endfunction

    task automatic model_eval();
        int a0, a1, b, d, c;
        a0 = -1; a1 = -1; b = -1; d = -1;
        e_alu0_en = 0; e_alu1_en = 0; e_bu_en = 0; e_du_en = 0;
        e_alu0_idx = 0; e_alu1_idx = 0; e_bu_idx = 0; e_du_idx = 0;
        e_sel = '0;
        if (!rst || flush) begin
            nxt_wait = 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (req_ready[i] && !m_infl[i]) begin
                    c = int'(req_class[2*i +: 2]);
                    if (c == 0) begin
                        if (a0 < 0 || age(i) < age(a0)) begin a1 = a0; a0 = i; end
                        else if (a1 < 0 || age(i) < age(a1)) a1 = i;
                    end else if (c == 1) begin
                        if (b < 0 || age(i) < age(b)) b = i;
                    end else if (c == 2) begin
                        if (d < 0 || age(i) < age(d)) d = i;
                    end
                end
            end
            if (a0 >= 0) begin e_alu0_en = 1; e_alu0_idx = a0; e_sel[a0] = 1'b1; end
            if (a1 >= 0) begin e_alu1_en = 1; e_alu1_idx = a1; e_sel[a1] = 1'b1; end
            if (b  >= 0) begin e_bu_en   = 1; e_bu_idx   = b;  e_sel[b]  = 1'b1; end
            if (d >= 0 && !m_wait && !du_busy) begin
                e_du_en = 1; e_du_idx = d; e_sel[d] = 1'b1;
            end
            nxt_wait = e_du_en ? 1'b1 : ((m_wait && du_done) ? 1'b0 : m_wait);
        end
    endtask

    task automatic cycle();
        model_eval();
        @(posedge clk);
        #1;
        check("alu0_en",  alu0_en,  e_alu0_en);
        check("alu1_en",  alu1_en,  e_alu1_en);
        check("bu_en",    bu_en,    e_bu_en);
        check("du_en",    du_en,    e_du_en);
        check("alu0_idx", alu0_idx, e_alu0_idx);
        check("alu1_idx", alu1_idx, e_alu1_idx);
        check("bu_idx",   bu_idx,   e_bu_idx);
        check("du_idx",   du_idx,   e_du_idx);
        check("sel_mask", sel_mask, e_sel);
        m_infl = e_sel;
        m_wait = nxt_wait;
    endtask

    task automatic set_entry(input int i, input logic [1:0] c);
        req_class[2*i +: 2] = c;
        req_ready[i]        = 1'b1;
    endtask

    task automatic clear_inputs();
        req_ready = '0;
        req_class = '1;
        du_busy   = 1'b0;
        du_done   = 1'b0;
        flush     = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        head_ptr = '0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        cycle();
        check("reset_sel", sel_mask, 0);
        rst = 1'b1;

        // Age order with inflight suppression
        set_entry(3, 2'b00); set_entry(5, 2'b00); set_entry(9, 2'b00);
        cycle();
        check("r030_alu0_idx", alu0_idx, 3);
        check("r030_alu1_idx", alu1_idx, 5);
        cycle();
        check("r030_alu0_idx_b", alu0_idx, 9);
        check("r030_alu1_en_b", alu1_en, 0);
        clear_inputs(); cycle();

        // Wrap-around age order
        head_ptr = 4'd14;
        set_entry(1, 2'b00); set_entry(15, 2'b00);
        cycle();
        check("r031_alu0_idx", alu0_idx, 15);
        check("r031_alu1_idx", alu1_idx, 1);
        clear_inputs(); head_ptr = '0; cycle();

        // DU handshake
        set_entry(4, 2'b10);
        cycle();
        check("r032_du_en", du_en, 1);
        check("r032_du_idx", du_idx, 4);
        req_ready[4] = 1'b0;
        set_entry(6, 2'b10);
        cycle(); check("r032_wait_a", du_en, 0);
        cycle(); check("r032_wait_b", du_en, 0);
        du_done = 1'b1;
        cycle(); check("r032_done_cyc", du_en, 0);
        du_done = 1'b0;
        cycle();
        check("r032_regrant_en", du_en, 1);
        check("r032_regrant_idx", du_idx, 6);
        clear_inputs(); du_done = 1'b1; cycle(); du_done = 1'b0; cycle();

        // du_busy blocking
        du_busy = 1'b1;
        set_entry(2, 2'b10);
        repeat (5) cycle();
        check("r033_busy", du_en, 0);
        du_busy = 1'b0;
        cycle();
        check("r033_en", du_en, 1);
        check("r033_idx", du_idx, 2);

        // Flush in WAIT with du_done, then reset mid-operation
        req_ready[2] = 1'b0;
        set_entry(0, 2'b00); set_entry(3, 2'b10); set_entry(7, 2'b01);
        flush = 1'b1; du_done = 1'b1;
        cycle();
        check("r034_flush_sel", sel_mask, 0);
        check("r034_flush_alu0", alu0_en, 0);
        flush = 1'b0; du_done = 1'b0;
        cycle();
        check("r034_idle_du_en", du_en, 1);
        check("r034_idle_du_idx", du_idx, 3);
        rst = 1'b0;
        cycle();
        check("r034_rst_sel", sel_mask, 0);
        check("r034_rst_du", du_en, 0);
        rst = 1'b1;
        clear_inputs(); cycle();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            req_ready = DEPTH'($urandom());
            req_class = (2*DEPTH)'({$urandom(), $urandom()});
            head_ptr  = IDX_W'($urandom_range(0, DEPTH - 1));
            du_busy   = ($urandom_range(0, 3) == 0);
            du_done   = ($urandom_range(0, 4) == 0);
            flush     = ($urandom_range(0, 49) == 0);
            rst       = ($urandom_range(0, 99) != 0);
            cycle();
        end
        clear_inputs(); rst = 1'b1;

`ifdef ISSUE_SELECT_PERF_EN
        rst = 1'b0; cycle(); rst = 1'b1;
        check("perf_reset", stall_cnt, 0);
        du_busy = 1'b1;
        set_entry(2, 2'b10);
        repeat (70000) @(posedge clk);
        #1;
        check("perf_saturate", stall_cnt, 16'hFFFF);
        clear_inputs();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/issue_select.md
ISSUE_SELECT -- requirements
Module: issue_select

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of issue-window entries; IDX_W = clog2(DEPTH).
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  synchronous, active-low reset.
REQ-004 SHALL have port flush  in  1  pipeline flush, synchronous, active-high.
REQ-005 SHALL have port req_ready  in  DEPTH  bit i: entry i valid, both sources woken, not yet selected.
REQ-006 SHALL have port req_class  in  2*DEPTH  per-entry FU class: 00 ALU, 01 BU, 10 DU, 11 none.
REQ-007 SHALL have port head_ptr  in  IDX_W  index of the oldest window entry.
REQ-008 SHALL have port du_busy  in  1  data unit cannot accept an operation.
REQ-009 SHALL have port du_done  in  1  data unit completed its outstanding operation.
REQ-010 SHALL have ports alu0_en, alu1_en, bu_en, du_en  out  1 each  grant valid per FU.
REQ-011 SHALL have ports alu0_idx, alu1_idx, bu_idx, du_idx  out  IDX_W each  granted entry index.
REQ-012 SHALL have port sel_mask  out  DEPTH  one-hot OR of all entries granted this cycle.

Function
REQ-013 SHALL compute candidates each cycle as req_ready AND NOT inflight_mask, where inflight_mask is the registered sel_mask of the previous cycle.
REQ-014 SHALL pick by age: circular scan starting at head_ptr, wrapping DEPTH-1 -> 0; lower age distance wins.
REQ-015 SHALL grant alu0 the oldest ALU candidate and alu1 the second-oldest ALU candidate; alu1 never granted when alu0 is not.
REQ-016 SHALL grant bu the oldest BU candidate, independent of ALU grants.
REQ-017 SHALL grant du the oldest DU candidate only when DU FSM is IDLE and du_busy=0.
REQ-018 SHALL register all grant outputs: candidates sampled in cycle N appear on *_en/*_idx/sel_mask in cycle N+1 (latency 1); held for exactly one cycle.
REQ-019 SHALL implement DU FSM states IDLE, WAIT: IDLE->WAIT on a DU grant; WAIT->IDLE on du_done; du_done in IDLE ignored.
REQ-020 SHALL grant at most one entry per FU per cycle and never grant one entry to two FUs.
REQ-021 SHALL drive *_idx to 0 whenever the matching *_en is 0.
REQ-022 SHALL, on flush, clear all grant registers, inflight_mask, and return DU FSM to IDLE in the next cycle; flush overrides simultaneous du_done and new grants.
REQ-023 SHALL ignore entries whose class is 11 and produce no grant when no candidate exists.

Reset
REQ-024 SHALL, while rst=0 at a clock edge, set all *_en=0, *_idx=0, sel_mask=0, inflight_mask=0, DU FSM=IDLE; reset takes priority over flush.
REQ-025 SHALL produce first possible grant in the cycle after the first edge with rst=1.

Configuration
REQ-026 SHALL, with macro ISSUE_SELECT_PERF_EN defined, add output stall_cnt (16 bits): increments each cycle with candidates nonzero and no grant, saturates at 0xFFFF, cleared by reset only.
REQ-027 SHALL, without ISSUE_SELECT_PERF_EN, omit the stall_cnt port and its counter entirely; all other behaviour identical.

Structure
REQ-028 SHALL take FU class encodings (CLS_ALU, CLS_BU, CLS_DU, CLS_NONE) and DU FSM state encodings from shared package issue_pkg.
REQ-029 SHALL use one sub-module age_pick (circular find-first from head_ptr over a DEPTH-bit vector, outputs found flag and index), instantiated per pick; second ALU pick uses the vector with the first pick masked out.

Verification
REQ-030 SHALL cover: head_ptr=0, ALU ready at entries 3,5,9 -> next cycle alu0_idx=3, alu1_idx=5; following cycle 3,5 suppressed by inflight, so with req unchanged alu0_idx=9, alu1_en=0.
REQ-031 SHALL cover: head_ptr=14, ALU ready at entries 1 and 15 -> alu0_idx=15, alu1_idx=1 (wrap-around age order).
REQ-032 SHALL cover: DU ready at entry 4, du_busy=0 -> du_en=1, du_idx=4, FSM WAIT; DU ready at entry 6 not granted until du_done pulse, then granted two cycles later.
REQ-033 SHALL cover: du_busy=1 with DU ready at entry 2 -> du_en=0 indefinitely; du_busy drop -> du_en=1, du_idx=2 next cycle.
REQ-034 SHALL cover: flush asserted in WAIT with du_done same cycle -> next cycle all *_en=0, FSM IDLE, sel_mask=0; rst=0 mid-operation -> same values.
REQ-035 SHALL cover: ISSUE_SELECT_PERF_EN defined, du_busy=1 with only DU candidate for 70000 cycles -> stall_cnt=0xFFFF.
